// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART receive-side blocks.
package uart_pkg;

   localparam int unsigned BYTE_W             = 8;
   localparam int unsigned CLK_HZ             = 50_000_000;
   // 100 ms inter-byte gap at the system clock rate
   localparam int unsigned DEF_TIMEOUT_CYCLES = CLK_HZ / 10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_ACK     = 2'd2,
      ST_HOLD    = 2'd3
   } state_t;

endpackage

// File: rtl/uart_gap_timer.sv
// Saturating gap counter: counts while run is high, flags the last allowed cycle.
module uart_gap_timer #(
   parameter int unsigned LIMIT = 100,
   parameter int unsigned CNT_W = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic expire_c
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] cnt;

   // Holds at LAST instead of wrapping
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (run && (cnt != LAST)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign expire_c = run && (cnt == LAST);

endmodule

// File: rtl/uart_frame_rx.sv
// Collects FRAME_BYTES bytes from the UART receiver into one frame with a
// valid/ready handshake; drops partial frames after an inter-byte timeout.
module uart_frame_rx
   import uart_pkg::*;
#(
   parameter int unsigned FRAME_BYTES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int unsigned CNT_W          = 23
) (
   input  logic                          clock_50MHZ,
   input  logic                          reset,
   input  logic                          rdy,
   input  logic [BYTE_W-1:0]             dout,
   output logic                          rdy_clr,
   output logic [BYTE_W*FRAME_BYTES-1:0] frame_data,
   output logic                          frame_valid,
   input  logic                          frame_ready,
   output logic                          frame_err,
   output logic                          busy
);

   localparam int unsigned FRAME_W  = BYTE_W * FRAME_BYTES;
   localparam int unsigned IDX_W    = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

   state_t             state, state_n;
   logic [IDX_W-1:0]   idx, idx_n;
   logic [FRAME_W-1:0] data_n;
   logic               rdy_clr_n, valid_n, err_n;
   logic               expire_c;

   // Counter is held cleared outside COLLECT and only advances while no byte is pending
   uart_gap_timer #(
      .LIMIT (TIMEOUT_CYCLES),
      .CNT_W (CNT_W)
   ) u_gap_timer (
      .clk      (clock_50MHZ),
      .rst      (reset),
      .clear    (state != ST_COLLECT),
      .run      ((state == ST_COLLECT) && !rdy),
      .expire_c (expire_c)
   );

   always_comb begin
      state_n   = state;
      idx_n     = idx;
      data_n    = frame_data;
      rdy_clr_n = 1'b0;
      valid_n   = 1'b0;
      err_n     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rdy) begin
               data_n[FRAME_W-1 -: BYTE_W] = dout;
               rdy_clr_n = 1'b1;
               idx_n     = '0;
               state_n   = ST_ACK;
            end
         end
         ST_ACK: begin
            if (rdy) begin
               rdy_clr_n = 1'b1;
            end else if (idx == LAST_IDX) begin
               valid_n = 1'b1;
               state_n = ST_HOLD;
            end else begin
               idx_n   = idx + IDX_W'(1);
               state_n = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            // A byte arriving on the expiry cycle takes priority over the timeout
            if (rdy) begin
               for (int k = 0; k < FRAME_BYTES; k++) begin
                  if (idx == IDX_W'(k)) begin
                     data_n[BYTE_W*(FRAME_BYTES-k)-1 -: BYTE_W] = dout;
                  end
               end
               rdy_clr_n = 1'b1;
               state_n   = ST_ACK;
            end else if (expire_c) begin
               err_n   = 1'b1;
               idx_n   = '0;
               state_n = ST_IDLE;
            end
         end
         ST_HOLD: begin
            // No rdy_clr here, so the receiver keeps the next byte pending
            if (frame_ready) begin
               state_n = ST_IDLE;
            end else begin
               valid_n = 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock_50MHZ) begin
      if (reset) begin
         state       <= ST_IDLE;
         idx         <= '0;
         frame_data  <= '0;
         rdy_clr     <= 1'b0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         frame_data  <= data_n;
         rdy_clr     <= rdy_clr_n;
         frame_valid <= valid_n;
         frame_err   <= err_n;
         busy        <= (state_n != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: a 2-byte instance and a 1-byte instance,
// each driven by a small model of the UART receiver's rdy/rdy_clr handshake.
module tb_uart_frame_rx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [1:0] rdy;
   logic [7:0] dout [2];
   logic [1:0] frame_ready;
   wire  [1:0] rdy_clr;
   wire  [1:0] fv;
   wire  [1:0] fe;
   wire  [1:0] busy;
   wire  [15:0] fd2;
   wire  [7:0]  fd1;

   int n_tests = 0;
   int n_fail  = 0;

   uart_frame_rx #(.FRAME_BYTES(2), .TIMEOUT_CYCLES(100), .CNT_W(7)) dut2 (
      .clock_50MHZ (clk),
      .reset       (reset),
      .rdy         (rdy[0]),
      .dout        (dout[0]),
      .rdy_clr     (rdy_clr[0]),
      .frame_data  (fd2),
      .frame_valid (fv[0]),
      .frame_ready (frame_ready[0]),
      .frame_err   (fe[0]),
      .busy        (busy[0])
   );

   uart_frame_rx #(.FRAME_BYTES(1), .TIMEOUT_CYCLES(100), .CNT_W(7)) dut1 (
      .clock_50MHZ (clk),
      .reset       (reset),
      .rdy         (rdy[1]),
      .dout        (dout[1]),
      .rdy_clr     (rdy_clr[1]),
      .frame_data  (fd1),
      .frame_valid (fv[1]),
      .frame_ready (frame_ready[1]),
      .frame_err   (fe[1]),
      .busy        (busy[1])
   );

   int clr0 = 0, clr1 = 0, err0 = 0, frm1 = 0;
   always @(posedge rdy_clr[0]) clr0++;
   always @(posedge rdy_clr[1]) clr1++;
   always @(posedge fe[0])      err0++;
   always @(posedge fv[1])      frm1++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Receiver model: drops rdy one cycle after it sees rdy_clr
   task automatic finish_byte(input int s);
      int k = 0;
      @(negedge clk);
      while (rdy_clr[s] !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("rdy_clr_asserted", 32'(rdy_clr[s]), 1);
      @(negedge clk);
      check("rdy_clr_second_cycle", 32'(rdy_clr[s]), 1);
      rdy[s] = 1'b0;
   endtask

   task automatic send_byte(input int s, input logic [7:0] b);
      dout[s] = b;
      rdy[s]  = 1'b1;
      finish_byte(s);
   endtask

   task automatic accept(input int s);
      frame_ready[s] = 1'b1;
      @(negedge clk);
      frame_ready[s] = 1'b0;
      check("valid_drop_after_accept", 32'(fv[s]), 0);
      check("busy_idle_after_accept", 32'(busy[s]), 0);
   endtask

   typedef struct {
      logic [7:0]  b0;
      logic [7:0]  b1;
      int          gap;
      logic [15:0] exp;
   } vec2_t;

   typedef struct {
      logic [7:0] b;
      logic [7:0] exp;
   } vec1_t;

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, expected completion within 500000 time units");
      $fatal(1);
   end

   initial begin
      vec2_t v2 [4];
      vec1_t v1 [4];
      int c, e, f, seen, bad_data, bad_clr, bad_valid;

      v2[0] = '{8'hA5, 8'h3C, 20, 16'hA53C};
      v2[1] = '{8'hBE, 8'hEF, 1,  16'hBEEF};
      v2[2] = '{8'h00, 8'hFF, 5,  16'h00FF};
      v2[3] = '{8'h80, 8'h01, 50, 16'h8001};
      v1[0] = '{8'hC3, 8'hC3};
      v1[1] = '{8'h00, 8'h00};
      v1[2] = '{8'hFF, 8'hFF};
      v1[3] = '{8'h5A, 8'h5A};

      reset = 1'b1;
      rdy = 2'b00;
      dout[0] = 8'h00;
      dout[1] = 8'h00;
      frame_ready = 2'b10;
      repeat (3) @(negedge clk);
      check("reset_rdy_clr", 32'(rdy_clr), 0);
      check("reset_valid", 32'(fv), 0);
      check("reset_err", 32'(fe), 0);
      check("reset_busy", 32'(busy), 0);
      check("reset_data2", 32'(fd2), 0);
      check("reset_data1", 32'(fd1), 0);
      reset = 1'b0;
      @(negedge clk);

      // Two-byte frames from the vector table
      for (int i = 0; i < 4; i++) begin
         c = clr0;
         e = err0;
         send_byte(0, v2[i].b0);
         check("busy_in_frame", 32'(busy[0]), 1);
         repeat (v2[i].gap) @(negedge clk);
         check("no_valid_mid_frame", 32'(fv[0]), 0);
         send_byte(0, v2[i].b1);
         @(negedge clk);
         check("frame_valid_n3", 32'(fv[0]), 1);
         check("frame_data", 32'(fd2), 32'(v2[i].exp));
         check("rdy_clr_pulses", 32'(clr0 - c), 2);
         check("no_frame_err", 32'(err0 - e), 0);
         accept(0);
         check("data_retained", 32'(fd2), 32'(v2[i].exp));
      end

      // Backpressure: third byte waits while the frame is held
      send_byte(0, 8'hA5);
      repeat (20) @(negedge clk);
      send_byte(0, 8'h3C);
      @(negedge clk);
      check("hold_valid", 32'(fv[0]), 1);
      dout[0] = 8'h77;
      rdy[0] = 1'b1;
      bad_data = 0;
      bad_clr = 0;
      bad_valid = 0;
      repeat (50) begin
         @(negedge clk);
         if (fd2 !== 16'hA53C) bad_data++;
         if (rdy_clr[0] !== 1'b0) bad_clr++;
         if (fv[0] !== 1'b1) bad_valid++;
      end
      check("hold_data_stable_cycles_bad", 32'(bad_data), 0);
      check("hold_no_rdy_clr_cycles_bad", 32'(bad_clr), 0);
      check("hold_valid_cycles_bad", 32'(bad_valid), 0);
      accept(0);
      finish_byte(0);
      repeat (3) @(negedge clk);
      send_byte(0, 8'h01);
      @(negedge clk);
      check("pending_byte_valid", 32'(fv[0]), 1);
      check("pending_byte_msb", 32'(fd2), 32'h7701);
      accept(0);

      // Timeout drops a partial frame
      e = err0;
      send_byte(0, 8'h11);
      seen = 0;
      repeat (100) begin
         @(negedge clk);
         if (fe[0]) seen++;
      end
      check("no_early_err", 32'(seen), 0);
      @(negedge clk);
      check("timeout_err_pulse", 32'(fe[0]), 1);
      check("timeout_busy_low", 32'(busy[0]), 0);
      @(negedge clk);
      check("timeout_err_one_cycle", 32'(fe[0]), 0);
      send_byte(0, 8'h22);
      repeat (5) @(negedge clk);
      send_byte(0, 8'h33);
      @(negedge clk);
      check("after_timeout_valid", 32'(fv[0]), 1);
      check("after_timeout_data", 32'(fd2), 32'h2233);
      check("timeout_err_count", 32'(err0 - e), 1);
      accept(0);

      // Byte arriving exactly on the expiry cycle wins
      e = err0;
      send_byte(0, 8'h11);
      repeat (100) @(negedge clk);
      send_byte(0, 8'h55);
      @(negedge clk);
      check("race_valid", 32'(fv[0]), 1);
      check("race_data", 32'(fd2), 32'h1155);
      check("race_no_err", 32'(err0 - e), 0);
      accept(0);

      // Reset mid-frame
      e = err0;
      send_byte(0, 8'h12);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset_rdy_clr", 32'(rdy_clr[0]), 0);
      check("midreset_valid", 32'(fv[0]), 0);
      check("midreset_err", 32'(fe[0]), 0);
      check("midreset_busy", 32'(busy[0]), 0);
      check("midreset_data", 32'(fd2), 0);
      send_byte(0, 8'hBE);
      repeat (3) @(negedge clk);
      send_byte(0, 8'hEF);
      @(negedge clk);
      check("post_reset_valid", 32'(fv[0]), 1);
      check("post_reset_data", 32'(fd2), 32'hBEEF);
      check("post_reset_no_err", 32'(err0 - e), 0);
      accept(0);

      // Single-byte frames, back to back, frame_ready tied high
      c = clr1;
      f = frm1;
      for (int i = 0; i < 4; i++) begin
         send_byte(1, v1[i].b);
         @(negedge clk);
         check("fb1_valid", 32'(fv[1]), 1);
         check("fb1_data", 32'(fd1), 32'(v1[i].exp));
      end
      @(negedge clk);
      check("fb1_valid_drop", 32'(fv[1]), 0);
      check("fb1_frame_count", 32'(frm1 - f), 4);
      check("fb1_rdy_clr_count", 32'(clr1 - c), 4);
      check("fb1_no_err", 32'(fe[1]), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
